ucsbece154a_rf_sb: RTL and testbench

Parametrised successor to the single-write-port register file. Adds width/depth parameters, a second write port for late (multicycle/load) results, and a per-register pending scoreboard with a pending-count output. Sits in the decode stage of the pipelined core; hazard logic uses the busy outputs to stall dependent instructions.

---
 rtl/ucsbece154a_rf_sb_pkg.sv | 13 +
 rtl/ucsbece154a_rf_sb_if.sv | 44 ++++
 rtl/ucsbece154a_sb_pend.sv | 70 +++++++
 rtl/ucsbece154a_rf_sb.sv | 89 ++++++++
 tb/tb_ucsbece154a_rf_sb.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/ucsbece154a_rf_sb_pkg.sv
// ucsbece154a_rf_sb_pkg
// Shared definitions for the scoreboarded register file:
//   XLEN_DEF  - default data width
//   NREG_DEF  - default register count (power of 2, >= 2)
//   REG_ZERO  - hard-wired zero register index
// Optional build macro used by this slice: UCSBECE154A_RF_BYPASS_EN
package ucsbece154a_rf_sb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/ucsbece154a_rf_sb_if.sv
// ucsbece154a_rf_sb_if
// Decode-stage bus of the scoreboarded register file.
//   read  : a1_i/a2_i -> rd1_o/rd2_o, busy1_o/busy2_o (combinational)
//   port A: we3_i, a3_i, wd3_i (pipeline writeback)
//   port B: we4_i, a4_i, wd4_i (late / multicycle result)
//   issue : iss_i, iss_a_i (mark destination pending), flush_i
//   status: pend_cnt_o (registered pending count)
// master = decode/hazard logic, slave = register file.
interface ucsbece154a_rf_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) ();
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   a1_i;
    logic [AW-1:0]   a2_i;
    logic [XLEN-1:0] rd1_o;
    logic [XLEN-1:0] rd2_o;
    logic            busy1_o;
    logic            busy2_o;
    logic            we3_i;
    logic [AW-1:0]   a3_i;
    logic [XLEN-1:0] wd3_i;
    logic            we4_i;
    logic [AW-1:0]   a4_i;
    logic [XLEN-1:0] wd4_i;
    logic            iss_i;
    logic [AW-1:0]   iss_a_i;
    logic            flush_i;
    logic [AW:0]     pend_cnt_o;

    modport master (
        output a1_i, a2_i, we3_i, a3_i, wd3_i, we4_i, a4_i, wd4_i,
               iss_i, iss_a_i, flush_i,
        input  rd1_o, rd2_o, busy1_o, busy2_o, pend_cnt_o
    );

    modport slave (
        input  a1_i, a2_i, we3_i, a3_i, wd3_i, we4_i, a4_i, wd4_i,
               iss_i, iss_a_i, flush_i,
        output rd1_o, rd2_o, busy1_o, busy2_o, pend_cnt_o
    );

endinterface

// File: rtl/ucsbece154a_sb_pend.sv
// ucsbece154a_sb_pend
// Pending-register scoreboard.
//   clk, reset          : clock, async active-high reset
//   we3_i/a3_i, we4_i/a4_i : writes that retire (clear) a pending bit
//   iss_i/iss_a_i       : issue that sets a pending bit
//   flush_i             : clear all pending bits (issue same cycle still sets)
//   pend_o              : registered pending vector (bit 0 always 0)
//   drop_o              : bits being cleared this cycle and not re-issued
//   pend_cnt_o          : registered popcount of pend_o
module ucsbece154a_sb_pend
    import ucsbece154a_rf_sb_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we3_i,
    input  logic [AW-1:0]   a3_i,
    input  logic            we4_i,
    input  logic [AW-1:0]   a4_i,
    input  logic            iss_i,
    input  logic [AW-1:0]   iss_a_i,
    input  logic            flush_i,
    output logic [NREG-1:0] pend_o,
    output logic [NREG-1:0] drop_o,
    output logic [AW:0]     pend_cnt_o
);

    logic [NREG-1:0] set_v;
    logic [NREG-1:0] clr_v;
    logic [NREG-1:0] pend_nxt;
    logic [AW:0]     cnt_nxt;

    // Clear first, then set: a new producer issued this cycle wins over
    // both a retiring write and a flush.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path leaves it unassigned (which would infer a latch).
        set_v   = '0;
        clr_v   = '0;
        cnt_nxt = '0;
        if (iss_i && iss_a_i != AW'(REG_ZERO)) set_v[iss_a_i] = 1'b1;
        if (we3_i && a3_i != AW'(REG_ZERO))    clr_v[a3_i]    = 1'b1;
        if (we4_i && a4_i != AW'(REG_ZERO))    clr_v[a4_i]    = 1'b1;
        if (flush_i)                           clr_v          = '1;
        pend_nxt    = (pend_o & ~clr_v) | set_v;
        pend_nxt[0] = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
        end
    end

    assign drop_o = clr_v & ~set_v;

    // The count is computed from the next vector so it tracks the
    // post-edge state on the same edge instead of lagging by one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_o     <= '0;
            pend_cnt_o <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops sample pre-edge values regardless of statement order.
            pend_o     <= pend_nxt;
            pend_cnt_o <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ucsbece154a_rf_sb.sv
// ucsbece154a_rf_sb
// Two-read, two-write register file with per-register pending scoreboard.
//   clk, reset : clock, async active-high reset (clears data and pending)
//   bus        : ucsbece154a_rf_sb_if.slave (reads, busy, write ports A/B,
//                issue, flush, pending count)
// Register 0 reads 0 and is never busy; writes/issues to it are dropped.
// Port A data wins when both ports write the same register.
// Build option UCSBECE154A_RF_BYPASS_EN: write-through reads (port A over
// port B) and busy drops in the cycle the pending bit is retired.
module ucsbece154a_rf_sb
    import ucsbece154a_rf_sb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic             clk,
    input  logic             reset,
    ucsbece154a_rf_sb_if.slave bus
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] drop;

    ucsbece154a_sb_pend #(
        .NREG (NREG),
        .AW   (AW)
    ) u_pend (
        .clk        (clk),
        .reset      (reset),
        .we3_i      (bus.we3_i),
        .a3_i       (bus.a3_i),
        .we4_i      (bus.we4_i),
        .a4_i       (bus.a4_i),
        .iss_i      (bus.iss_i),
        .iss_a_i    (bus.iss_a_i),
        .flush_i    (bus.flush_i),
        .pend_o     (pend),
        .drop_o     (drop),
        .pend_cnt_o (bus.pend_cnt_o)
    );

    // Port B is written first so port A overrides it on an address tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is reset explicitly because registers must
            // read 0 after reset; this forces flops rather than RAM macros.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (bus.we4_i && bus.a4_i != AW'(REG_ZERO)) regs[bus.a4_i] <= bus.wd4_i;
            if (bus.we3_i && bus.a3_i != AW'(REG_ZERO)) regs[bus.a3_i] <= bus.wd3_i;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        logic [XLEN-1:0] d;
        d = regs[a];
`ifdef UCSBECE154A_RF_BYPASS_EN
        if (bus.we4_i && a == bus.a4_i) d = bus.wd4_i;
        if (bus.we3_i && a == bus.a3_i) d = bus.wd3_i;
`endif
        if (a == AW'(REG_ZERO)) d = '0;
        return d;
    endfunction

    function automatic logic busy_port(input logic [AW-1:0] a);
        logic b;
`ifdef UCSBECE154A_RF_BYPASS_EN
        b = pend[a] & ~drop[a];
`else
        b = pend[a];
`endif
        return b;
    endfunction

    assign bus.rd1_o   = read_port(bus.a1_i);
    assign bus.rd2_o   = read_port(bus.a2_i);
    assign bus.busy1_o = busy_port(bus.a1_i);
    assign bus.busy2_o = busy_port(bus.a2_i);

`ifndef UCSBECE154A_RF_BYPASS_EN
    // drop is only consumed by the write-through variant.
    logic unused_drop;
    assign unused_drop = ^drop;
`endif

endmodule

// File: tb/tb_ucsbece154a_rf_sb.sv
// tb_ucsbece154a_rf_sb
// Directed-vector bench for ucsbece154a_rf_sb with hand-computed
// expectations; honours UCSBECE154A_RF_BYPASS_EN for same-cycle reads.
module tb_ucsbece154a_rf_sb;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    ucsbece154a_rf_sb_if #(.XLEN(32), .NREG(32)) bus ();

    ucsbece154a_rf_sb #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we3_i   = 1'b0;
        bus.we4_i   = 1'b0;
        bus.iss_i   = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a);
        bus.iss_i   = 1'b1;
        bus.iss_a_i = a;
        step();
        idle();
    endtask

    initial begin
        reset       = 1'b1;
        idle();
        bus.a1_i    = 5'd5;
        bus.a2_i    = 5'd6;
        bus.a3_i    = '0;
        bus.a4_i    = '0;
        bus.wd3_i   = '0;
        bus.wd4_i   = '0;
        bus.iss_a_i = '0;
        #1;
        check("rst_rd1", bus.rd1_o, 32'h0);
        check("rst_cnt", 32'(bus.pend_cnt_o), 32'd0);
        check("rst_busy1", 32'(bus.busy1_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Port A write to x10, observed in the same cycle and the next.
        bus.we3_i = 1'b1; bus.a3_i = 5'd10; bus.wd3_i = 32'h55; bus.a1_i = 5'd10;
        #1;
`ifdef UCSBECE154A_RF_BYPASS_EN
        check("byp_same", bus.rd1_o, 32'h55);
`else
        check("byp_same", bus.rd1_o, 32'h0);
`endif
        step(); idle();
        check("byp_next", bus.rd1_o, 32'h55);

        // Both ports hit x5: port A data stored.
        bus.we3_i = 1'b1; bus.a3_i = 5'd5; bus.wd3_i = 32'hDEADBEEF;
        bus.we4_i = 1'b1; bus.a4_i = 5'd5; bus.wd4_i = 32'h12345678;
        step(); idle();
        bus.a1_i = 5'd5;
        #1;
        check("dual_wr_x5", bus.rd1_o, 32'hDEADBEEF);

        // Issue x7 while writing non-pending x6.
        bus.iss_i = 1'b1; bus.iss_a_i = 5'd7;
        bus.we3_i = 1'b1; bus.a3_i = 5'd6; bus.wd3_i = 32'h66;
        step(); idle();
        bus.a1_i = 5'd7; bus.a2_i = 5'd6;
        #1;
        check("iss7_busy1", 32'(bus.busy1_o), 32'd1);
        check("iss7_cnt", 32'(bus.pend_cnt_o), 32'd1);
        check("x6_rd2", bus.rd2_o, 32'h66);
        check("x6_busy2", 32'(bus.busy2_o), 32'd0);

        // Port B retires x7.
        bus.we4_i = 1'b1; bus.a4_i = 5'd7; bus.wd4_i = 32'hA5;
        step(); idle();
        check("ret7_busy1", 32'(bus.busy1_o), 32'd0);
        check("ret7_rd1", bus.rd1_o, 32'hA5);
        check("ret7_cnt", 32'(bus.pend_cnt_o), 32'd0);

        // x9 pending, then issue and write x9 together: stays pending.
        issue(5'd9);
        bus.a1_i = 5'd9;
        #1;
        check("iss9_cnt", 32'(bus.pend_cnt_o), 32'd1);
        bus.iss_i = 1'b1; bus.iss_a_i = 5'd9;
        bus.we3_i = 1'b1; bus.a3_i = 5'd9; bus.wd3_i = 32'h99;
        step(); idle();
        check("reiss9_busy", 32'(bus.busy1_o), 32'd1);
        check("reiss9_cnt", 32'(bus.pend_cnt_o), 32'd1);
        check("reiss9_rd", bus.rd1_o, 32'h99);

        // Retire x9, pend x1..x3, then flush with issue x4.
        bus.we4_i = 1'b1; bus.a4_i = 5'd9; bus.wd4_i = 32'h9;
        step(); idle();
        check("ret9_cnt", 32'(bus.pend_cnt_o), 32'd0);
        issue(5'd1); issue(5'd2); issue(5'd3);
        check("p123_cnt", 32'(bus.pend_cnt_o), 32'd3);
        bus.flush_i = 1'b1; bus.iss_i = 1'b1; bus.iss_a_i = 5'd4;
        step(); idle();
        bus.a1_i = 5'd1; bus.a2_i = 5'd4;
        #1;
        check("flush_cnt", 32'(bus.pend_cnt_o), 32'd1);
        check("flush_x1", 32'(bus.busy1_o), 32'd0);
        check("flush_x4", 32'(bus.busy2_o), 32'd1);
        bus.a1_i = 5'd3;
        #1;
        check("flush_x3", 32'(bus.busy1_o), 32'd0);
        bus.a1_i = 5'd5;
        #1;
        check("flush_keep_x5", bus.rd1_o, 32'hDEADBEEF);

        // Register 0 ignores writes and issues.
        bus.we3_i = 1'b1; bus.a3_i = 5'd0; bus.wd3_i = 32'hFF;
        bus.we4_i = 1'b1; bus.a4_i = 5'd0; bus.wd4_i = 32'hEE;
        bus.iss_i = 1'b1; bus.iss_a_i = 5'd0;
        bus.a1_i  = 5'd0;
        #1;
        check("x0_rd_same", bus.rd1_o, 32'h0);
        check("x0_busy_same", 32'(bus.busy1_o), 32'd0);
        step(); idle();
        check("x0_rd", bus.rd1_o, 32'h0);
        check("x0_busy", 32'(bus.busy1_o), 32'd0);
        check("x0_cnt", 32'(bus.pend_cnt_o), 32'd1);

        // Three pending (x1, x2, x4), then reset mid-cycle.
        issue(5'd1); issue(5'd2);
        check("pre_rst_cnt", 32'(bus.pend_cnt_o), 32'd3);
        #2;
        bus.a1_i = 5'd5; bus.a2_i = 5'd6;
        reset = 1'b1;
        #1;
        check("mid_rst_x5", bus.rd1_o, 32'h0);
        check("mid_rst_x6", bus.rd2_o, 32'h0);
        check("mid_rst_cnt", 32'(bus.pend_cnt_o), 32'd0);
        bus.a1_i = 5'd1; bus.a2_i = 5'd4;
        #1;
        check("mid_rst_busy1", 32'(bus.busy1_o), 32'd0);
        check("mid_rst_busy2", 32'(bus.busy2_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
